// File: rtl/alu_writeback_buffer_pkg.sv
// Core types for the ALU result path: register index, data word and write-back entry.
// XLEN follows the RV32 build define.
package alu_writeback_buffer_pkg;

`ifdef RV32
  localparam int XLEN = 32;
`else
  localparam int XLEN = 64;
`endif

  typedef logic [XLEN-1:0] reg_data_t;
  typedef logic [4:0]      reg_idx_t;

  typedef struct packed {
    reg_idx_t  rd;
    reg_data_t data;
  } wb_entry_t;

  // W-form results are sign-extended from bit 31; on RV32 the loop is empty and data passes through.
  function automatic reg_data_t fmt_result(input reg_data_t raw, input logic w32);
    reg_data_t d;
    d = raw;
    if (w32) begin
      for (int b = 32; b < XLEN; b++) begin
        d[b] = raw[31];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/wb_bypass_match.sv
// Combinational bypass search over the write-back FIFO slots.
// The scan runs from head (oldest) to youngest, so the last match found wins.
module wb_bypass_match
  import alu_writeback_buffer_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  reg_idx_t         lookup_rd,
  output logic             hit,
  output reg_data_t        data
);

  logic [PW-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((lookup_rd != '0) && valid[idx] && (entries[idx].rd == lookup_rd)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/alu_writeback_buffer.sv
// In-order FIFO between the integer ALU and the register-file write port,
// with a youngest-wins bypass lookup over the queued results.
module alu_writeback_buffer
  import alu_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_flush,
  input  logic      i_valid,
  output logic      o_ready,
  input  reg_idx_t  i_rd,
  input  logic      i_w32,
  input  reg_data_t i_dest,
  output logic      o_wb_valid,
  input  logic      i_wb_ready,
  output reg_idx_t  o_wb_rd,
  output reg_data_t o_wb_data,
  input  reg_idx_t  i_lookup_rd,
  output logic      o_lookup_hit,
  output reg_data_t o_lookup_data,
  output logic      o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_nxt;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             push_hs;
  logic             alloc;
  logic             pop;

  // Ready looks only at registered count, so a full buffer never accepts even when popping.
  assign o_ready    = (count_q != CW'(DEPTH));
  assign o_wb_valid = (count_q != '0);
  assign o_empty    = (count_q == '0);
  assign o_wb_rd    = o_wb_valid ? mem[head_q].rd   : '0;
  assign o_wb_data  = o_wb_valid ? mem[head_q].data : '0;

  // x0 results complete the handshake but never take a slot.
  assign push_hs = i_valid & o_ready & ~i_flush;
  assign alloc   = push_hs & (i_rd != '0);
  assign pop     = o_wb_valid & i_wb_ready & ~i_flush;

  always_comb begin
    valid_nxt = valid_q;
    if (pop) begin
      valid_nxt[head_q] = 1'b0;
    end
    if (alloc) begin
      valid_nxt[tail_q] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      if (alloc) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({alloc, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; valid bits and count qualify every read.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && alloc) begin
      mem[tail_q] <= '{rd: i_rd, data: fmt_result(i_dest, i_w32)};
    end
  end

  wb_bypass_match #(
    .DEPTH (DEPTH)
  ) u_bypass (
    .entries   (mem),
    .valid     (valid_q),
    .head      (head_q),
    .lookup_rd (i_lookup_rd),
    .hit       (o_lookup_hit),
    .data      (o_lookup_data)
  );

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Scoreboard bench for alu_writeback_buffer: a queue model tracks accepted results,
// every cycle compares status, head and bypass outputs against it.
module tb_alu_writeback_buffer;
  import alu_writeback_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic      clk;
  logic      rst_n;
  logic      flush;
  logic      valid;
  logic      ready;
  reg_idx_t  rd;
  logic      w32;
  reg_data_t dest;
  logic      wb_valid;
  logic      wb_ready;
  reg_idx_t  wb_rd;
  reg_data_t wb_data;
  reg_idx_t  lookup_rd;
  logic      lookup_hit;
  reg_data_t lookup_data;
  logic      empty;

  int n_checks = 0;
  int n_fail   = 0;

  wb_entry_t model_q [$];

  alu_writeback_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flush       (flush),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_rd          (rd),
    .i_w32         (w32),
    .i_dest        (dest),
    .o_wb_valid    (wb_valid),
    .i_wb_ready    (wb_ready),
    .o_wb_rd       (wb_rd),
    .o_wb_data     (wb_data),
    .i_lookup_rd   (lookup_rd),
    .o_lookup_hit  (lookup_hit),
    .o_lookup_data (lookup_data),
    .o_empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic reg_data_t exp_fmt(input reg_data_t d, input logic w);
    if (w && XLEN == 64) return reg_data_t'($signed(d[31:0]));
    return d;
  endfunction

  task automatic set_push(input int r, input bit w, input logic [63:0] d);
    valid = 1'b1;
    rd    = 5'(r);
    w32   = w;
    dest  = reg_data_t'(d);
  endtask

  // Called just after a falling edge: check outputs, take one rising edge, update model.
  task automatic tick();
    bit        m_push;
    bit        m_pop;
    bit        lh;
    reg_data_t ld;
    int        sz;
    #1;
    sz = model_q.size();
    chk("ready",    64'(ready),    64'(sz != DEPTH));
    chk("wb_valid", 64'(wb_valid), 64'(sz != 0));
    chk("empty",    64'(empty),    64'(sz == 0));
    chk("wb_rd",    64'(wb_rd),    (sz != 0) ? 64'(model_q[0].rd)   : 64'(0));
    chk("wb_data",  64'(wb_data),  (sz != 0) ? 64'(model_q[0].data) : 64'(0));
    lh = 1'b0;
    ld = '0;
    if (lookup_rd != 5'd0) begin
      for (int i = sz - 1; i >= 0; i--) begin
        if (model_q[i].rd == lookup_rd) begin
          lh = 1'b1;
          ld = model_q[i].data;
          break;
        end
      end
    end
    chk("lookup_hit",  64'(lookup_hit),  64'(lh));
    chk("lookup_data", 64'(lookup_data), 64'(ld));
    m_pop  = (sz != 0) && wb_ready;
    m_push = valid && (sz != DEPTH) && (rd != 5'd0);
    @(posedge clk);
    if (!rst_n || flush) begin
      model_q.delete();
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(wb_entry_t'{rd: rd, data: exp_fmt(dest, w32)});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rd = '0; w32 = 1'b0;
    dest = '0; wb_ready = 1'b0; lookup_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lookup_rd = 5'd5;
    tick();
    rst_n = 1'b1;

    // single result held until the write port takes it
    set_push(5, 0, 64'h1234);
    tick();
    valid = 1'b0;
    chk("hold_rd",   64'(wb_rd),   64'd5);
    chk("hold_data", 64'(wb_data), 64'h1234);
    repeat (3) tick();
    chk("hold_late", 64'(wb_data), 64'h1234);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("drained_empty", 64'(empty), 64'd1);

    // W-form sign extension and plain pass-through
    set_push(3, 1, 64'h0000_0000_8000_0001);
    tick();
    valid = 1'b0;
    chk("w32_sext", 64'(wb_data), 64'(reg_data_t'(64'hFFFF_FFFF_8000_0001)));
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    set_push(3, 0, 64'h0000_0000_8000_0001);
    tick();
    valid = 1'b0;
    chk("w64_raw", 64'(wb_data), 64'(reg_data_t'(64'h0000_0000_8000_0001)));
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // fill, refuse while full even with a pop, then stream across pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      set_push(10 + i, 0, 64'(100 + i));
      tick();
    end
    chk("full_ready", 64'(ready), 64'd0);
    set_push(14, 0, 64'h99);
    wb_ready = 1'b1;
    tick();
    chk("ready_after_pop", 64'(ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      set_push(16 + i, 0, 64'(200 + i));
      tick();
    end
    valid = 1'b0;
    repeat (DEPTH + 1) tick();
    wb_ready = 1'b0;

    // bypass: youngest match wins, x0 and absent index miss, same-cycle push invisible
    set_push(7, 0, 64'hA); tick();
    set_push(9, 0, 64'hB); tick();
    set_push(7, 0, 64'hC); lookup_rd = 5'd7; tick();
    valid = 1'b0;
    chk("byp_hit",  64'(lookup_hit),  64'd1);
    chk("byp_data", 64'(lookup_data), 64'hC);
    lookup_rd = 5'd0; #1;
    chk("byp_x0_hit",  64'(lookup_hit),  64'd0);
    chk("byp_x0_data", 64'(lookup_data), 64'd0);
    lookup_rd = 5'd2; #1;
    chk("byp_miss_hit",  64'(lookup_hit),  64'd0);
    chk("byp_miss_data", 64'(lookup_data), 64'd0);
    lookup_rd = 5'd20;
    set_push(20, 0, 64'h77);
    tick();
    valid = 1'b0;
    chk("byp_new_hit", 64'(lookup_hit), 64'd1);
    wb_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    wb_ready = 1'b0;

    // x0 push handshakes without allocating
    set_push(0, 0, 64'h55);
    #1;
    chk("x0_ready", 64'(ready), 64'd1);
    tick();
    valid = 1'b0;
    chk("x0_empty", 64'(empty),    64'd1);
    chk("x0_wbv",   64'(wb_valid), 64'd0);
    tick();

    // flush with push and pop pending, then the same with reset
    lookup_rd = 5'd2;
    for (int i = 1; i <= 3; i++) begin
      set_push(i, 0, 64'(300 + i));
      tick();
    end
    set_push(4, 0, 64'h304);
    wb_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; valid = 1'b0; wb_ready = 1'b0;
    chk("flush_empty", 64'(empty),      64'd1);
    chk("flush_wbv",   64'(wb_valid),   64'd0);
    chk("flush_hit",   64'(lookup_hit), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      set_push(i, 0, 64'(400 + i));
      tick();
    end
    set_push(4, 0, 64'h404);
    wb_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; valid = 1'b0; wb_ready = 1'b0;
    chk("rst_empty", 64'(empty),      64'd1);
    chk("rst_wbv",   64'(wb_valid),   64'd0);
    chk("rst_hit",   64'(lookup_hit), 64'd0);
    chk("rst_ready", 64'(ready),      64'd1);

    // random traffic against the scoreboard
    for (int n = 0; n < 300; n++) begin
      valid     = ($urandom_range(0, 9) < 7);
      rd        = 5'($urandom_range(0, 7));
      w32       = 1'($urandom_range(0, 1));
      dest      = reg_data_t'({$urandom(), $urandom()});
      wb_ready  = ($urandom_range(0, 9) < 5);
      lookup_rd = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; valid = 1'b0; wb_ready = 1'b1;
    repeat (DEPTH + 1) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback_buffer.md
# alu_writeback_buffer

Result-side companion to the integer ALU. It accepts each completed ALU result with its destination register index and applies the RV64 W-form sign extension. Results are queued in a small in-order FIFO and drained to the register-file write port over a valid/ready handshake. While results wait, it provides a combinational bypass lookup so the operand-read stage can forward pending values to the next ALU operation.

## Interface
Parameters:
- DEPTH, 4: number of FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock. One clock domain; all state changes on its rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_flush  in  1  discard all queued results (pipeline redirect).
- i_valid  in  1  ALU result present.
- o_ready  out  1  buffer can accept a result this cycle.
- i_rd  in  5  destination register index.
- i_w32  in  1  result is a W-form (32-bit) op.
- i_dest  in  XLEN  raw ALU result (reg_data_t).
- o_wb_valid  out  1  head entry valid for register-file write.
- i_wb_ready  in  1  register file takes the head entry.
- o_wb_rd  out  5  head destination index.
- o_wb_data  out  XLEN  head data.
- i_lookup_rd  in  5  bypass query index.
- o_lookup_hit  out  1  a queued entry targets i_lookup_rd.
- o_lookup_data  out  XLEN  data of the youngest matching entry.
- o_empty  out  1  no entries queued.

## Operation
- Push occurs when i_valid & o_ready & ~i_flush.
- Pop occurs when o_wb_valid & i_wb_ready & ~i_flush.
- Data formatting on push:
  - RV64 with i_w32=1: stored data = {{32{i_dest[31]}}, i_dest[31:0]}.
  - RV32: i_w32 is ignored and data is stored unchanged.
- A push with i_rd==0 completes the handshake but allocates no entry; x0 is never written and never hits.
- The FIFO keeps head and tail pointers of width log2(DEPTH) plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Status outputs:
  - o_ready = (count != DEPTH). It depends only on registered state, so a full buffer refuses a push even while a pop happens in the same cycle.
  - o_wb_valid = (count != 0).
  - o_wb_rd and o_wb_data come from the head entry, and are 0 when empty.
- Simultaneous push and pop with count in 1..DEPTH-1: count is unchanged, head and tail both advance.
- Bypass lookup is combinational over the valid entries.
  - When several entries match, the entry closest to the tail (youngest) wins.
  - o_lookup_hit=0 and o_lookup_data=0 on a miss or when i_lookup_rd==0.
  - An entry being pushed in the current cycle is not visible to the lookup.
- i_flush sets count, head and tail to 0 on the next edge. It overrides a push or pop in the same cycle, and the handshakes are ignored.

## Timing
- Reset (i_rst_n=0 at an edge) sets count, head and tail to 0 and clears the valid bits. Resulting outputs:
  - o_ready=1, o_wb_valid=0, o_empty=1.
  - o_wb_rd=0, o_wb_data=0, o_lookup_hit=0, o_lookup_data=0.
- Reset mid-drain drops all entries with no write.
- Latency:
  - A result pushed at edge N appears at the head, with o_wb_valid=1, in the cycle after N when the buffer was empty.
  - A result pushed at edge N is visible to the lookup in the cycle after N.
- Throughput: one push and one pop per cycle in steady state.
- The head is held stable while o_wb_valid=1 and i_wb_ready=0.

## Structure
- Shared core package additions:
  - reg_idx_t (5-bit logic).
  - wb_entry_t struct {reg_idx_t rd; reg_data_t data}.
  - XLEN derived from the existing RV32 define (32 when set, otherwise 64).
- reg_data_t is reused unchanged.
- One sub-module, wb_bypass_match: combinational youngest-match priority search over the DEPTH entries. Inputs: entries, valid mask, head, lookup index. Outputs: hit, data.
- FIFO storage and control stay inline in alu_writeback_buffer.

## Test plan
- Reset, then push rd=5, data=0x1234 with i_wb_ready=0 → next cycle o_wb_valid=1, o_wb_rd=5, o_wb_data=0x1234; the values hold until i_wb_ready=1, after which o_empty=1.
- RV64: push rd=3, i_w32=1, i_dest=0x0000_0000_8000_0001 → o_wb_data=0xFFFF_FFFF_8000_0001. Repeat with i_w32=0 → data unchanged.
- Fill to DEPTH=4 with i_wb_ready=0 → o_ready=0. Assert i_valid and i_wb_ready together → no push that cycle. The next cycle o_ready=1, and the drained order matches the push order across pointer wrap.
- Push rd=7 with 0xA, rd=9 with 0xB, then rd=7 with 0xC; lookup rd=7 → hit, 0xC. Lookup rd=0 or rd=2 → hit=0, data=0.
- Push with i_rd=0 → handshake completes, o_empty remains 1, o_wb_valid never rises.
- Three entries queued; assert i_flush together with i_valid and i_wb_ready → next cycle o_empty=1, o_wb_valid=0, no entry added. Repeat with i_rst_n=0 instead of i_flush → same empty state.
